ps2_text_reader: RTL and testbench
==================================

Name: ps2_text_reader

Overview:
- Converts PS/2 key-event words into ASCII bytes and buffers them in a show-ahead FIFO for a host consumer (OSD text capture, console log).
- It is the inverse of the text-to-keystroke writer and uses the same 11-bit key-event format and the same character map.
- Sits between the HPS/PS2 key source and any byte-stream consumer.

Parameters:
- DEPTH, 16, number of FIFO entries; must be a power of 2, at least 2.
- LW, $clog2(DEPTH+1), width of the level output.

Ports:
- clk, input, 1, system clock.
- reset_n, input, 1, asynchronous active-low reset.
- ps2_key, input, 11, key event: [10] toggle strobe, [9] 1 = press / 0 = release, [8:0] scancode (bit 8 = extended).
- ascii_byte, output, 8, FIFO head byte; valid only while ascii_valid = 1.
- ascii_valid, output, 1, FIFO not empty.
- ascii_ready, input, 1, consumer pop; a pop occurs on a clk edge where ascii_valid & ascii_ready.
- level, output, LW, current FIFO occupancy, 0..DEPTH.
- overflow, output, 1, sticky flag: a byte was dropped because the FIFO was full.
- overflow_clr, input, 1, synchronous clear of overflow.
- shift_state, output, 1, left-shift or right-shift currently held.
- caps_state, output, 1, caps-lock latch; tied to 0 when the optional feature is out.

Behaviour:
- Reset (asynchronous, reset_n low) forces: FIFO empty; ascii_valid = 0; ascii_byte = 0; level = 0; overflow = 0; shift flags = 0; caps = 0; primed = 0.
- Priming: the first clk edge after reset release copies ps2_key[10] into last_strobe and sets primed. No event is taken on that edge, so a stale strobe level cannot generate a byte.
- Event detect, stage 1: when primed and ps2_key[10] != last_strobe, the block registers {pressed, code} as an event and updates last_strobe. One event is accepted per toggle; there is no back-pressure on ps2_key.
- Shift tracking: scancode 0x012 (left shift) and 0x059 (right shift) set or clear their own flag on press or release. shift_state = left | right. Shift events never produce a byte.
- Release events of any other key are discarded.
- Lookup, stage 2: a press event is mapped combinationally using the shift value at event time, then pushed to the FIFO on the next edge.
- Latency: a toggle sampled at edge N gives ascii_valid = 1 after edge N+1, provided the FIFO was empty.
- Unshifted map:
  - A–Z -> 0x41–0x5A.
  - 0–9 -> 0x30–0x39.
  - 0x054 -> ':'.
  - 0x04C -> ';'.
  - 0x04A -> '/'.
  - 0x049 -> '.'.
  - 0x041 -> ','.
  - 0x04E -> '-'.
  - 0x029 -> ' '.
  - 0x05A (Enter) -> 0x0A.
  - 0x066 (Backspace) -> 0x08.
- Shifted map:
  - 1 -> '!', 2 -> '"', 3 -> '#', 4 -> '$', 5 -> '%'.
  - 6 -> '&', 7 -> ''', 8 -> '(', 9 -> ')', 0 -> '@'.
  - 0x054 -> '*', 0x04E -> '=', 0x04C -> '+'.
  - 0x041 -> '<', 0x049 -> '>', 0x04A -> '?'.
  - Letters, space, Enter and Backspace produce the same byte as unshifted.
- Any other scancode, including every extended code, produces no push.
- FIFO:
  - Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - ascii_byte always shows mem[rd_ptr].
- Push and pop on the same edge:
  - Allowed at any level, including full; level is unchanged.
  - When the FIFO is empty, the push wins and no pop occurs, because ascii_valid was 0.
- Push when full with no pop: the byte is dropped, overflow is set, and FIFO contents are unchanged.
- Pop when empty is ignored.
- overflow_clr and an overflow set on the same edge: set wins.
- An event in flight at reset assertion is lost; there is no partial push.

Optional Feature:
- Macro: PS2_TEXT_READER_CAPSLOCK_EN.
- Defined:
  - Press of 0x058 toggles caps, which is driven on caps_state.
  - Letters map to lowercase 0x61–0x7A unless (shift XOR caps) = 1, which gives uppercase.
  - 0x058 never produces a byte.
- Undefined:
  - caps_state = 0.
  - 0x058 is an unmapped key.
  - Letters are always uppercase.

Test Plan:
- Release reset with ps2_key[10] = 1 and hold for 10 cycles -> ascii_valid stays 0 and level = 0.
- Toggle strobe with press 0x01C (A), ascii_ready = 0 -> ascii_valid = 1 two edges later, ascii_byte = 0x41, level = 1. Then a release of 0x01C -> no push, level stays 1.
- Press 0x012, press 0x016, release 0x016, release 0x012 -> one byte 0x21 ('!'). shift_state is 1 between the shift press and the shift release, then 0.
- With DEPTH = 16, push 17 'Z' presses with ascii_ready = 0 -> level = 16, overflow = 1. Then pulse overflow_clr -> overflow = 0. Drain with ascii_ready = 1 -> 16 bytes of 0x5A, after which ascii_valid = 0.
- FIFO full with ascii_ready = 1, press 0x045 (0) -> level stays 16, overflow stays 0, and byte 0x30 appears as the last one drained.
- With PS2_TEXT_READER_CAPSLOCK_EN defined: press 'Q' -> 0x71. Press and release 0x058 -> caps_state = 1. Press 'Q' -> 0x51. Press 'Q' with shift held -> 0x71.

Source files
------------

// File: rtl/ps2_text_reader.sv
// PS/2 key-event to ASCII converter feeding a show-ahead byte FIFO.
// Optional caps-lock support is enabled by defining PS2_TEXT_READER_CAPSLOCK_EN.
module ps2_text_reader #(
  parameter int DEPTH = 16,
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [10:0]   ps2_key,
  output logic [7:0]    ascii_byte,
  output logic          ascii_valid,
  input  logic          ascii_ready,
  output logic [LW-1:0] level,
  output logic          overflow,
  input  logic          overflow_clr,
  output logic          shift_state,
  output logic          caps_state
);

  localparam int PW = $clog2(DEPTH);

  logic          primed_q, primed_d;
  logic          last_strobe_q, last_strobe_d;
  logic          ev_vld_q, ev_vld_d;
  logic          ev_pressed_q, ev_pressed_d;
  logic [8:0]    ev_code_q, ev_code_d;
  logic          shift_l_q, shift_l_d;
  logic          shift_r_q, shift_r_d;
  logic          caps_q;
  logic          shift_q;
  logic          strobe_edge;

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  logic          map_hit;
  logic [7:0]    map_byte;
  logic [7:0]    letter;
  logic          letter_lc;
  logic          fifo_empty, fifo_full, do_push, do_pop, ovf_set;

  assign shift_q     = shift_l_q | shift_r_q;
  // Until primed the strobe level is only captured, never treated as a toggle.
  assign strobe_edge = primed_q && (ps2_key[10] != last_strobe_q);

  always_comb begin
    primed_d      = 1'b1;
    last_strobe_d = ps2_key[10];
    ev_vld_d      = strobe_edge;
    ev_pressed_d  = ps2_key[9];
    ev_code_d     = ps2_key[8:0];
    shift_l_d     = shift_l_q;
    shift_r_d     = shift_r_q;
    if (strobe_edge && ps2_key[8:0] == 9'h012) shift_l_d = ps2_key[9];
    if (strobe_edge && ps2_key[8:0] == 9'h059) shift_r_d = ps2_key[9];
  end

`ifdef PS2_TEXT_READER_CAPSLOCK_EN
  logic caps_d;
  always_comb begin
    caps_d = caps_q;
    if (strobe_edge && ps2_key[9] && ps2_key[8:0] == 9'h058) caps_d = ~caps_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) caps_q <= 1'b0;
    else          caps_q <= caps_d;
  end
  assign letter_lc = ~(shift_q ^ caps_q);
`else
  assign caps_q    = 1'b0;
  assign letter_lc = 1'b0;
`endif

  always_comb begin
    map_hit  = 1'b0;
    map_byte = 8'h00;
    letter   = 8'h00;
    if (ev_vld_q && ev_pressed_q && !ev_code_q[8]) begin
      map_hit = 1'b1;
      case (ev_code_q[7:0])
        8'h1C: letter = 8'h41;  8'h32: letter = 8'h42;  8'h21: letter = 8'h43;
        8'h23: letter = 8'h44;  8'h24: letter = 8'h45;  8'h2B: letter = 8'h46;
        8'h34: letter = 8'h47;  8'h33: letter = 8'h48;  8'h43: letter = 8'h49;
        8'h3B: letter = 8'h4A;  8'h42: letter = 8'h4B;  8'h4B: letter = 8'h4C;
        8'h3A: letter = 8'h4D;  8'h31: letter = 8'h4E;  8'h44: letter = 8'h4F;
        8'h4D: letter = 8'h50;  8'h15: letter = 8'h51;  8'h2D: letter = 8'h52;
        8'h1B: letter = 8'h53;  8'h2C: letter = 8'h54;  8'h3C: letter = 8'h55;
        8'h2A: letter = 8'h56;  8'h1D: letter = 8'h57;  8'h22: letter = 8'h58;
        8'h35: letter = 8'h59;  8'h1A: letter = 8'h5A;
        8'h16: map_byte = shift_q ? 8'h21 : 8'h31;
        8'h1E: map_byte = shift_q ? 8'h22 : 8'h32;
        8'h26: map_byte = shift_q ? 8'h23 : 8'h33;
        8'h25: map_byte = shift_q ? 8'h24 : 8'h34;
        8'h2E: map_byte = shift_q ? 8'h25 : 8'h35;
        8'h36: map_byte = shift_q ? 8'h26 : 8'h36;
        8'h3D: map_byte = shift_q ? 8'h27 : 8'h37;
        8'h3E: map_byte = shift_q ? 8'h28 : 8'h38;
        8'h46: map_byte = shift_q ? 8'h29 : 8'h39;
        8'h45: map_byte = shift_q ? 8'h40 : 8'h30;
        8'h54: map_byte = shift_q ? 8'h2A : 8'h3A;
        8'h4C: map_byte = shift_q ? 8'h2B : 8'h3B;
        8'h4A: map_byte = shift_q ? 8'h3F : 8'h2F;
        8'h49: map_byte = shift_q ? 8'h3E : 8'h2E;
        8'h41: map_byte = shift_q ? 8'h3C : 8'h2C;
        8'h4E: map_byte = shift_q ? 8'h3D : 8'h2D;
        8'h29: map_byte = 8'h20;
        8'h5A: map_byte = 8'h0A;
        8'h66: map_byte = 8'h08;
        default: map_hit = 1'b0;
      endcase
      if (letter != 8'h00) map_byte = letter_lc ? (letter | 8'h20) : letter;
    end
  end

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == LW'(DEPTH));
  assign do_push    = map_hit && (!fifo_full || do_pop);
  assign do_pop     = !fifo_empty && ascii_ready;
  assign ovf_set    = map_hit && fifo_full && !do_pop;

  always_comb begin
    wr_ptr_d   = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = count_q;
    if (do_push && !do_pop) count_d = count_q + 1'b1;
    if (!do_push && do_pop) count_d = count_q - 1'b1;
    overflow_d = (overflow_q && !overflow_clr) || ovf_set;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      primed_q      <= 1'b0;
      last_strobe_q <= 1'b0;
      ev_vld_q      <= 1'b0;
      ev_pressed_q  <= 1'b0;
      ev_code_q     <= '0;
      shift_l_q     <= 1'b0;
      shift_r_q     <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      overflow_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
    end else begin
      primed_q      <= primed_d;
      last_strobe_q <= last_strobe_d;
      ev_vld_q      <= ev_vld_d;
      ev_pressed_q  <= ev_pressed_d;
      ev_code_q     <= ev_code_d;
      shift_l_q     <= shift_l_d;
      shift_r_q     <= shift_r_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      overflow_q    <= overflow_d;
      if (do_push) mem_q[wr_ptr_q] <= map_byte;
    end
  end

  assign ascii_byte  = mem_q[rd_ptr_q];
  assign ascii_valid = !fifo_empty;
  assign level       = count_q;
  assign overflow    = overflow_q;
  assign shift_state = shift_q;
  assign caps_state  = caps_q;

endmodule

// File: tb/tb_ps2_text_reader.sv
// Directed bench for ps2_text_reader; each task checks its own scenario inline.
module tb_ps2_text_reader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [10:0] ps2_key;
  logic [7:0]  ascii_byte;
  logic        ascii_valid;
  logic        ascii_ready;
  logic [4:0]  level;
  logic        overflow;
  logic        overflow_clr;
  logic        shift_state;
  logic        caps_state;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  ps2_text_reader #(.DEPTH(16)) dut (
    .clk(clk), .reset_n(reset_n), .ps2_key(ps2_key),
    .ascii_byte(ascii_byte), .ascii_valid(ascii_valid), .ascii_ready(ascii_ready),
    .level(level), .overflow(overflow), .overflow_clr(overflow_clr),
    .shift_state(shift_state), .caps_state(caps_state)
  );

  // Toggle the strobe with a new event; returns 1 time unit after the sampling edge.
  task automatic send(input logic pressed, input logic [8:0] code);
    ps2_key = {~ps2_key[10], pressed, code};
    @(posedge clk); #1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pop_one();
    ascii_ready = 1'b1;
    @(posedge clk); #1;
    ascii_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; ps2_key = 11'h400; ascii_ready = 1'b0; overflow_clr = 1'b0;
    #23 reset_n = 1'b1;
    repeat (10) tick();
    vecs++; if (ascii_valid !== 1'b0) begin errs++; $display("FAIL reset_valid got %b want 0", ascii_valid); end
    vecs++; if (level !== 5'd0) begin errs++; $display("FAIL reset_level got %0d want 0", level); end
    vecs++; if (ascii_byte !== 8'h00) begin errs++; $display("FAIL reset_byte got %h want 00", ascii_byte); end
    vecs++; if (overflow !== 1'b0) begin errs++; $display("FAIL reset_overflow got %b want 0", overflow); end
    vecs++; if (shift_state !== 1'b0) begin errs++; $display("FAIL reset_shift got %b want 0", shift_state); end
    vecs++; if (caps_state !== 1'b0) begin errs++; $display("FAIL reset_caps got %b want 0", caps_state); end
  endtask

  task automatic test_single_press();
    send(1'b1, 9'h01C);
    vecs++; if (ascii_valid !== 1'b0) begin errs++; $display("FAIL latency_early got %b want 0", ascii_valid); end
    tick();
    vecs++; if (ascii_valid !== 1'b1) begin errs++; $display("FAIL press_a_valid got %b want 1", ascii_valid); end
    vecs++; if (ascii_byte !== 8'h41) begin errs++; $display("FAIL press_a_byte got %h want 41", ascii_byte); end
    vecs++; if (level !== 5'd1) begin errs++; $display("FAIL press_a_level got %0d want 1", level); end
    send(1'b0, 9'h01C);
    tick(); tick();
    vecs++; if (level !== 5'd1) begin errs++; $display("FAIL release_a_level got %0d want 1", level); end
    send(1'b1, 9'h11C);
    tick(); tick();
    vecs++; if (level !== 5'd1) begin errs++; $display("FAIL extended_level got %0d want 1", level); end
    pop_one();
    vecs++; if (level !== 5'd0) begin errs++; $display("FAIL pop_a_level got %0d want 0", level); end
  endtask

  task automatic test_shift();
    send(1'b1, 9'h012);
    vecs++; if (shift_state !== 1'b1) begin errs++; $display("FAIL shift_held got %b want 1", shift_state); end
    send(1'b1, 9'h016);
    send(1'b0, 9'h016);
    vecs++; if (shift_state !== 1'b1) begin errs++; $display("FAIL shift_still got %b want 1", shift_state); end
    send(1'b0, 9'h012);
    vecs++; if (shift_state !== 1'b0) begin errs++; $display("FAIL shift_released got %b want 0", shift_state); end
    tick();
    vecs++; if (level !== 5'd1) begin errs++; $display("FAIL shift_level got %0d want 1", level); end
    vecs++; if (ascii_byte !== 8'h21) begin errs++; $display("FAIL shift_byte got %h want 21", ascii_byte); end
    pop_one();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 17; i++) send(1'b1, 9'h01A);
    tick();
    vecs++; if (level !== 5'd16) begin errs++; $display("FAIL ovf_level got %0d want 16", level); end
    vecs++; if (overflow !== 1'b1) begin errs++; $display("FAIL ovf_set got %b want 1", overflow); end
    overflow_clr = 1'b1; tick(); overflow_clr = 1'b0;
    vecs++; if (overflow !== 1'b0) begin errs++; $display("FAIL ovf_clr got %b want 0", overflow); end
    ascii_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      vecs++; if (ascii_valid !== 1'b1 || ascii_byte !== 8'h5A) begin
        errs++; $display("FAIL ovf_drain_%0d got v=%b %h want v=1 5a", i, ascii_valid, ascii_byte);
      end
      tick();
    end
    ascii_ready = 1'b0;
    vecs++; if (ascii_valid !== 1'b0) begin errs++; $display("FAIL ovf_drained got %b want 0", ascii_valid); end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 16; i++) send(1'b1, 9'h01A);
    tick();
    vecs++; if (level !== 5'd16) begin errs++; $display("FAIL full_level got %0d want 16", level); end
    send(1'b1, 9'h045);
    ascii_ready = 1'b1; tick(); ascii_ready = 1'b0;
    vecs++; if (level !== 5'd16) begin errs++; $display("FAIL fullpp_level got %0d want 16", level); end
    vecs++; if (overflow !== 1'b0) begin errs++; $display("FAIL fullpp_ovf got %b want 0", overflow); end
    ascii_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      logic [7:0] exp_b;
      exp_b = (i == 15) ? 8'h30 : 8'h5A;
      vecs++; if (ascii_valid !== 1'b1 || ascii_byte !== exp_b) begin
        errs++; $display("FAIL fullpp_drain_%0d got v=%b %h want v=1 %h", i, ascii_valid, ascii_byte, exp_b);
      end
      tick();
    end
    ascii_ready = 1'b0;
    vecs++; if (ascii_valid !== 1'b0) begin errs++; $display("FAIL fullpp_drained got %b want 0", ascii_valid); end
  endtask

  task automatic test_back_to_back();
    ascii_ready = 1'b1;
    send(1'b1, 9'h032);
    send(1'b1, 9'h021);
    vecs++; if (level !== 5'd1 || ascii_byte !== 8'h42) begin
      errs++; $display("FAIL b2b_first got lvl=%0d %h want lvl=1 42", level, ascii_byte);
    end
    tick();
    vecs++; if (level !== 5'd1 || ascii_byte !== 8'h43) begin
      errs++; $display("FAIL b2b_second got lvl=%0d %h want lvl=1 43", level, ascii_byte);
    end
    tick();
    vecs++; if (level !== 5'd0) begin errs++; $display("FAIL b2b_empty got %0d want 0", level); end
    tick();
    vecs++; if (level !== 5'd0) begin errs++; $display("FAIL pop_empty got %0d want 0", level); end
    ascii_ready = 1'b0;
  endtask

  task automatic test_capslock();
`ifdef PS2_TEXT_READER_CAPSLOCK_EN
    send(1'b1, 9'h015); tick();
    vecs++; if (ascii_byte !== 8'h71) begin errs++; $display("FAIL caps_q_lower got %h want 71", ascii_byte); end
    pop_one();
    send(1'b1, 9'h058); send(1'b0, 9'h058); tick();
    vecs++; if (caps_state !== 1'b1) begin errs++; $display("FAIL caps_on got %b want 1", caps_state); end
    vecs++; if (level !== 5'd0) begin errs++; $display("FAIL caps_nobyte got %0d want 0", level); end
    send(1'b1, 9'h015); tick();
    vecs++; if (ascii_byte !== 8'h51) begin errs++; $display("FAIL caps_q_upper got %h want 51", ascii_byte); end
    pop_one();
    send(1'b1, 9'h012); send(1'b1, 9'h015); send(1'b0, 9'h012);
    vecs++; if (ascii_byte !== 8'h71) begin errs++; $display("FAIL caps_shift_q got %h want 71", ascii_byte); end
    pop_one();
`else
    send(1'b1, 9'h015); tick();
    vecs++; if (ascii_byte !== 8'h51) begin errs++; $display("FAIL q_upper got %h want 51", ascii_byte); end
    pop_one();
    send(1'b1, 9'h058); tick();
    vecs++; if (level !== 5'd0) begin errs++; $display("FAIL capskey_unmapped got %0d want 0", level); end
    vecs++; if (caps_state !== 1'b0) begin errs++; $display("FAIL caps_tied got %b want 0", caps_state); end
`endif
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_shift();
    test_overflow();
    test_full_push_pop();
    test_back_to_back();
    test_capslock();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
